// File: rtl/operand_pair_pkg.sv
// -----------------------------------------------------------------------------
// operand_pair_pkg
// Shared defaults for the operand pair buffer and its side FIFOs:
//   DATA_W_DEF  operand width (matches the mux op1/op2 width)
//   DEPTH_DEF   entries per side FIFO (power of two, >= 2)
//   CNT_W_DEF   width of the equal-pair match counter
//   level_w()   width of an occupancy counter able to hold 0..depth
// -----------------------------------------------------------------------------
package operand_pair_pkg;

  localparam int unsigned DATA_W_DEF = 31;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  // Occupancy runs 0..depth inclusive, so one bit more than a pointer.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/operand_pair_buffer_op_fifo.sv
// -----------------------------------------------------------------------------
// op_fifo
// Single-side circular FIFO used twice by operand_pair_buffer.
// Ports:
//   aclk, arst   clock, asynchronous active-low reset
//   flush        synchronous clear of pointers and level (memory untouched)
//   push, wdata  write request and data; ignored while full
//   pop          read request; ignored while empty
//   head         entry at the read pointer (raw, not gated)
//   level        occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module op_fifo
  import operand_pair_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                        aclk,
  input  logic                        arst,
  input  logic                        flush,
  input  logic                        push,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        pop,
  output logic [DATA_W-1:0]           head,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = level_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Full/empty guards live here too, so the FIFO stays consistent even if a
  // caller asserts push/pop without checking level first.
  assign do_push = push && (level != LVL_W'(DEPTH));
  assign do_pop  = pop  && (level != '0);
  assign head    = mem[rd_ptr];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would make ordering matter.
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      // NOTE: the memory is reset deliberately so op1/op2 are defined after
      // reset; this makes it flops rather than a RAM macro.
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/operand_pair_buffer.sv
// -----------------------------------------------------------------------------
// operand_pair_buffer
// Buffers two independent operand streams (A, B) and presents one aligned pair
// to the equality-select mux stage only when both sides hold data.
// Ports:
//   aclk, arst             clock, asynchronous active-low reset
//   flush                  synchronous clear of both FIFOs
//   a_valid/a_ready/a_data A operand handshake
//   b_valid/b_ready/b_data B operand handshake
//   pair_valid/pair_ready  pair handshake; a beat pops both FIFOs together
//   op1, op2               head operands, forced to zero when no pair
//   a_level, b_level       per-side occupancy
//   match_cnt              consumed pairs with op1 == op2 (saturating)
// Build option: OPERAND_PAIR_MATCH_CNT_EN enables the match counter; when
// undefined, match_cnt is tied to zero.
// -----------------------------------------------------------------------------
module operand_pair_buffer
  import operand_pair_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                      aclk,
  input  logic                      arst,
  input  logic                      flush,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [DATA_W-1:0]         a_data,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [DATA_W-1:0]         b_data,
  output logic                      pair_valid,
  input  logic                      pair_ready,
  output logic [DATA_W-1:0]         op1,
  output logic [DATA_W-1:0]         op2,
  output logic [level_w(DEPTH)-1:0] a_level,
  output logic [level_w(DEPTH)-1:0] b_level,
  output logic [CNT_W-1:0]          match_cnt
);

  localparam int unsigned LVL_W = level_w(DEPTH);

  logic [DATA_W-1:0] a_head;
  logic [DATA_W-1:0] b_head;
  logic              pop;

  // Ready and pair_valid come from registered levels only, so a pop in the
  // same cycle never opens a full FIFO and no input reaches an output.
  assign a_ready    = (a_level != LVL_W'(DEPTH));
  assign b_ready    = (b_level != LVL_W'(DEPTH));
  assign pair_valid = (a_level != '0) && (b_level != '0);
  assign pop        = pair_valid && pair_ready;

  // NOTE: every output of this block is assigned on all paths, so no latch.
  always_comb begin
    op1 = '0;
    op2 = '0;
    if (pair_valid) begin
      op1 = a_head;
      op2 = b_head;
    end
  end

  op_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
    .aclk  (aclk),
    .arst  (arst),
    .flush (flush),
    .push  (a_valid && a_ready),
    .wdata (a_data),
    .pop   (pop),
    .head  (a_head),
    .level (a_level)
  );

  op_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
    .aclk  (aclk),
    .arst  (arst),
    .flush (flush),
    .push  (b_valid && b_ready),
    .wdata (b_data),
    .pop   (pop),
    .head  (b_head),
    .level (b_level)
  );

`ifdef OPERAND_PAIR_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  // A flush cancels the pop in its cycle, so that pair is not counted.
  // The counter survives flush; only reset clears it.
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      cnt <= '0;
    end else if (pop && !flush && (op1 == op2) && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_operand_pair_buffer.sv
// -----------------------------------------------------------------------------
// tb_operand_pair_buffer
// Directed bench for operand_pair_buffer with default parameters
// (DATA_W=31, DEPTH=4, CNT_W=16). Expected match counts follow the
// OPERAND_PAIR_MATCH_CNT_EN build option.
// -----------------------------------------------------------------------------
module tb_operand_pair_buffer;

  localparam int DATA_W = 31;
  localparam int LVL_W  = 3;
  localparam int CNT_W  = 16;

`ifdef OPERAND_PAIR_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              aclk = 1'b0;
  logic              arst;
  logic              flush;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [DATA_W-1:0] a_data, b_data;
  logic              pair_valid, pair_ready;
  logic [DATA_W-1:0] op1, op2;
  logic [LVL_W-1:0]  a_level, b_level;
  logic [CNT_W-1:0]  match_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_matches = 0;

  always #5 aclk = ~aclk;

  operand_pair_buffer dut (
    .aclk       (aclk),
    .arst       (arst),
    .flush      (flush),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_data     (b_data),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .op1        (op1),
    .op2        (op2),
    .a_level    (a_level),
    .b_level    (b_level),
    .match_cnt  (match_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    a_valid    = 1'b0;
    b_valid    = 1'b0;
    pair_ready = 1'b0;
    flush      = 1'b0;
    a_data     = '0;
    b_data     = '0;
  endtask

  function automatic logic [63:0] exp_cnt();
    return CNT_EN ? 64'(exp_matches) : 64'd0;
  endfunction

  initial begin
    // ---------------- reset with random inputs ----------------
    arst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_valid    = 1'($urandom);
      b_valid    = 1'($urandom);
      pair_ready = 1'($urandom);
      flush      = 1'($urandom);
      a_data     = DATA_W'($urandom);
      b_data     = DATA_W'($urandom);
      step();
    end
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);
    check("rst_pair_valid", pair_valid, 0);
    check("rst_op1", op1, 0);
    check("rst_op2", op2, 0);
    check("rst_a_level", a_level, 0);
    check("rst_b_level", b_level, 0);
    check("rst_match_cnt", match_cnt, 0);
    idle();
    @(negedge aclk);
    arst = 1'b1;
    step();

    // ---------------- skew: A=5,7,9 then B=5 ----------------
    pair_ready = 1'b1;
    a_valid = 1'b1;
    a_data = 5; step();
    check("skew_a_level1", a_level, 1);
    check("skew_no_pair1", pair_valid, 0);
    a_data = 7; step();
    a_data = 9; step();
    a_valid = 1'b0;
    check("skew_a_level3", a_level, 3);
    step(); step();
    check("skew_no_pair_wait", pair_valid, 0);
    check("skew_gated_op1", op1, 0);
    b_valid = 1'b1; b_data = 5; step();
    b_valid = 1'b0;
    check("skew_pair_valid", pair_valid, 1);
    check("skew_op1", op1, 5);
    check("skew_op2", op2, 5);
    step();  // pair (5,5) consumed
    exp_matches++;
    check("skew_a_level2", a_level, 2);
    check("skew_b_level0", b_level, 0);
    check("skew_pair_done", pair_valid, 0);
    check("skew_match_cnt", match_cnt, exp_cnt());
    pair_ready = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    check("skew_flush_a_level", a_level, 0);
    check("skew_flush_cnt", match_cnt, exp_cnt());

    // ---------------- full: 4 A pushes, 5th dropped ----------------
    a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_data = DATA_W'(10 + i);
      step();
    end
    check("full_a_level", a_level, 4);
    check("full_a_ready", a_ready, 0);
    check("full_b_ready", b_ready, 1);
    a_data = 99; step();
    a_valid = 1'b0;
    check("full_drop_level", a_level, 4);
    // Drain with matching B values; 99 must never appear.
    pair_ready = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_data = DATA_W'(10 + i);
      step();
      check("full_drain_op1", op1, 64'(10 + i));
      check("full_drain_op2", op2, 64'(10 + i));
      if (i == 1) check("full_ready_back", a_ready, 1);
    end
    b_valid = 1'b0;
    step();
    exp_matches += 4;
    check("full_drained_a", a_level, 0);
    check("full_drained_pv", pair_valid, 0);
    check("full_match_cnt", match_cnt, exp_cnt());
    pair_ready = 1'b0;

    // ---------------- backpressure ----------------
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = 20; b_data = 30; step();
    a_data = 21; b_data = 31; step();
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_op1_stable", op1, 20);
      check("bp_op2_stable", op2, 30);
      check("bp_levels", {a_level, b_level}, {3'd2, 3'd2});
      step();
    end
    pair_ready = 1'b1;
    step();
    check("bp_pair2_op1", op1, 21);
    check("bp_pair2_op2", op2, 31);
    check("bp_levels1", {a_level, b_level}, {3'd1, 3'd1});
    step();
    check("bp_empty", pair_valid, 0);
    check("bp_levels0", {a_level, b_level}, {3'd0, 3'd0});
    check("bp_match_cnt", match_cnt, exp_cnt());

    // ---------------- wrap-around streaming ----------------
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      a_data = DATA_W'(i); b_data = DATA_W'(i);
      step();
      check("wrap_pv", pair_valid, 1);
      check("wrap_op1", op1, 64'(i));
      check("wrap_op2", op2, 64'(i));
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    exp_matches += 10;
    check("wrap_levels0", {a_level, b_level}, {3'd0, 3'd0});
    check("wrap_match_cnt", match_cnt, exp_cnt());
    pair_ready = 1'b0;

    // ---------------- flush mid-stream ----------------
    a_valid = 1'b1;
    a_data = 40; b_valid = 1'b1; b_data = 50; step();
    b_valid = 1'b0;
    a_data = 41; step();
    a_data = 42; step();
    check("fl_levels_before", {a_level, b_level}, {3'd3, 3'd1});
    a_data = 43; b_valid = 1'b1; b_data = 51;
    pair_ready = 1'b1; flush = 1'b1;
    step();
    idle();
    check("fl_levels", {a_level, b_level}, {3'd0, 3'd0});
    check("fl_pv", pair_valid, 0);
    check("fl_op1", op1, 0);
    check("fl_ready", {a_ready, b_ready}, 2'b11);
    check("fl_match_cnt", match_cnt, exp_cnt());
    // Fresh data after flush comes out first.
    a_valid = 1'b1; b_valid = 1'b1; a_data = 60; b_data = 61; step();
    a_valid = 1'b0; b_valid = 1'b0;
    check("fl_after_op1", op1, 60);
    check("fl_after_op2", op2, 61);

    // ---------------- asynchronous reset mid-transfer ----------------
    #2 arst = 1'b0;
    #1;
    check("arst_levels", {a_level, b_level}, {3'd0, 3'd0});
    check("arst_pv", pair_valid, 0);
    check("arst_op2", op2, 0);
    check("arst_match_cnt", match_cnt, 0);
    @(negedge aclk);
    arst = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
